// File: rtl/serial_fsub_if.sv
// serial_fsub_if: start/busy/done handshake, operands and result of the serial subtractor
interface serial_fsub_if #(parameter int W = 8);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    modport master (output start, a, b, bin, input busy, done, diff, bout);
    modport slave  (input start, a, b, bin, output busy, done, diff, bout);
endinterface

// File: rtl/serial_fsub.sv
// serial_fsub: bit-serial a - b - bin built on one full-subtractor cell, LSB first
module serial_fsub #(
    parameter int W = 8
) (
    input logic          clk,
    input logic          rst,
    serial_fsub_if.slave bus
);
    localparam int CW = $clog2(W) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state_q, state_d;
    logic [W-1:0]  sa_q, sa_d, sb_q, sb_d, diff_q, diff_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bw_q, bw_d, bout_q, bout_d;
    logic          ai, bi, d, bw_n;
    assign ai   = sa_q[0];
    assign bi   = sb_q[0];
    assign d    = ai ^ bi ^ bw_q;
    assign bw_n = (~ai & bi) | (~ai & bw_q) | (bi & bw_q);
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        bw_d    = bw_q;
        bout_d  = bout_q;
        if (state_q == RUN) begin
            sa_d   = sa_q >> 1;
            sb_d   = sb_q >> 1;
            diff_d = {d, diff_q[W-1:1]};
            bw_d   = bw_n;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
                state_d = DONE;
                bout_d  = bw_n;
            end
        end else if (bus.start) begin
            sa_d    = bus.a;
            sb_d    = bus.b;
            bw_d    = bus.bin;
            cnt_d   = '0;
            state_d = RUN;
        end else begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            bw_q    <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            bw_q    <= bw_d;
            bout_q  <= bout_d;
        end
    end
    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
endmodule
